// File: rtl/cpu_wb_multi_pkg.sv
// Shared definitions for the multi-issue writeback path.
//   ISSUE_NUM_DEFAULT : default number of write channels
//   MAX_ISSUE         : widest bundle the helpers support
//   Word_t, RegAddr_t : register-file word and address types
//   WbReq_t           : one register-file write request
//   popcount_issue    : number of set enables in a (zero-extended) bundle mask
package cpu_wb_multi_pkg;

    localparam int ISSUE_NUM_DEFAULT = 2;
    localparam int MAX_ISSUE         = 4;

    typedef logic [31:0] Word_t;
    typedef logic [4:0]  RegAddr_t;

    typedef struct packed {
        logic     we;
        RegAddr_t waddr;
        Word_t    wdata;
    } WbReq_t;

    function automatic logic [2:0] popcount_issue(input logic [MAX_ISSUE-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < MAX_ISSUE; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/cpu_wb_multi_conflict_mask.sv
// Combinational write-enable mask for a bundle of register-file writes.
// A channel keeps its enable only if it targets a non-zero register and no
// later (higher-index, younger) channel in the same bundle writes that register.
//   we_i    : per-channel write enables
//   waddr_i : per-channel destinations, channel k at [k*REG_ADDR_W +: REG_ADDR_W]
//   eff_we  : surviving enables
module cpu_wb_multi_conflict_mask #(
    parameter int ISSUE_NUM  = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic [ISSUE_NUM-1:0]            we_i,
    input  logic [ISSUE_NUM*REG_ADDR_W-1:0] waddr_i,
    output logic [ISSUE_NUM-1:0]            eff_we
);

    always_comb begin
        eff_we = '0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            eff_we[k] = we_i[k] && (waddr_i[k*REG_ADDR_W +: REG_ADDR_W] != '0);
            // Younger channel to the same register wins.
            for (int j = k + 1; j < ISSUE_NUM; j++) begin
                if (we_i[j] &&
                    (waddr_i[j*REG_ADDR_W +: REG_ADDR_W] == waddr_i[k*REG_ADDR_W +: REG_ADDR_W])) begin
                    eff_we[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_wb_multi.sv
// Writeback pipeline register for the multi-issue core.
// Registers ISSUE_NUM write requests from MEM for the register file, with
// stall hold, flush, $0 suppression, same-address masking and a retired-write
// counter.
//   clk, rst      : clock, asynchronous active-high reset
//   stall_i       : hold outputs and counter
//   flush_i       : clear output enables (overrides stall)
//   we_i/waddr_i/wdata_i : incoming bundle, channel k in slice k
//   we_o/waddr_o/wdata_o : registered bundle toward the register file
//   retired_cnt_o : modulo-2^CNT_W count of committed writes
module cpu_wb_multi
    import cpu_wb_multi_pkg::*;
#(
    parameter int ISSUE_NUM  = ISSUE_NUM_DEFAULT,
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall_i,
    input  logic                            flush_i,
    input  logic [ISSUE_NUM-1:0]            we_i,
    input  logic [ISSUE_NUM*REG_ADDR_W-1:0] waddr_i,
    input  logic [ISSUE_NUM*WORD_W-1:0]     wdata_i,
    output logic [ISSUE_NUM-1:0]            we_o,
    output logic [ISSUE_NUM*REG_ADDR_W-1:0] waddr_o,
    output logic [ISSUE_NUM*WORD_W-1:0]     wdata_o,
    output logic [CNT_W-1:0]                retired_cnt_o
);

    logic [ISSUE_NUM-1:0]            eff_we_p0;
    logic [MAX_ISSUE-1:0]            eff_we_ext_p0;
    logic [CNT_W-1:0]                inc_p0;

    logic [ISSUE_NUM-1:0]            we_p1;
    logic [ISSUE_NUM*REG_ADDR_W-1:0] waddr_p1;
    logic [ISSUE_NUM*WORD_W-1:0]     wdata_p1;
    logic [CNT_W-1:0]                cnt_p1;

    // ---- stage p0: combinational masking of the incoming bundle ----
    cpu_wb_multi_conflict_mask #(
        .ISSUE_NUM  (ISSUE_NUM),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mask (
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .eff_we  (eff_we_p0)
    );

    assign eff_we_ext_p0 = MAX_ISSUE'(eff_we_p0);
    assign inc_p0        = CNT_W'(popcount_issue(eff_we_ext_p0));

    // ---- stage p1: writeback register and retired counter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_p1    <= '0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            cnt_p1   <= '0;
        end else if (flush_i) begin
            // Address/data are don't-care with enables cleared; keep them to save toggles.
            we_p1 <= '0;
        end else if (!stall_i) begin
            we_p1    <= eff_we_p0;
            waddr_p1 <= waddr_i;
            wdata_p1 <= wdata_i;
            cnt_p1   <= cnt_p1 + inc_p0;
        end
    end

    assign we_o          = we_p1;
    assign waddr_o       = waddr_p1;
    assign wdata_o       = wdata_p1;
    assign retired_cnt_o = cnt_p1;

endmodule

// File: tb/tb_cpu_wb_multi.sv
module tb_cpu_wb_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2-issue, 32-bit counter instance
    logic        stall2, flush2;
    logic [1:0]  we2;
    logic [9:0]  waddr2;
    logic [63:0] wdata2;
    logic [1:0]  we_o2;
    logic [9:0]  waddr_o2;
    logic [63:0] wdata_o2;
    logic [31:0] cnt_o2;

    // 4-issue, 4-bit counter instance
    logic         stall4, flush4;
    logic [3:0]   we4;
    logic [19:0]  waddr4;
    logic [127:0] wdata4;
    logic [3:0]   we_o4;
    logic [19:0]  waddr_o4;
    logic [127:0] wdata_o4;
    logic [3:0]   cnt_o4;

    cpu_wb_multi #(.ISSUE_NUM(2), .WORD_W(32), .REG_ADDR_W(5), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst), .stall_i(stall2), .flush_i(flush2),
        .we_i(we2), .waddr_i(waddr2), .wdata_i(wdata2),
        .we_o(we_o2), .waddr_o(waddr_o2), .wdata_o(wdata_o2), .retired_cnt_o(cnt_o2)
    );

    cpu_wb_multi #(.ISSUE_NUM(4), .WORD_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall_i(stall4), .flush_i(flush4),
        .we_i(we4), .waddr_i(waddr4), .wdata_i(wdata4),
        .we_o(we_o4), .waddr_o(waddr_o4), .wdata_o(wdata_o4), .retired_cnt_o(cnt_o4)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [1:0]   m2_we;
    logic [9:0]   m2_addr;
    logic [63:0]  m2_data;
    logic [31:0]  m2_cnt;
    logic [3:0]   m4_we;
    logic [19:0]  m4_addr;
    logic [127:0] m4_data;
    logic [3:0]   m4_cnt;

    // "Last writer to each register wins; register 0 is never written."
    function automatic logic [3:0] ref_eff(input int n, input logic [3:0] we, input logic [19:0] addr);
        int         last [32];
        logic [3:0] r;
        r = '0;
        for (int a = 0; a < 32; a++) last[a] = -1;
        for (int k = 0; k < n; k++) if (we[k]) last[addr[k*5 +: 5]] = k;
        for (int k = 0; k < n; k++)
            if (we[k] && addr[k*5 +: 5] != 5'd0 && last[addr[k*5 +: 5]] == k) r[k] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m2_we = '0; m2_addr = '0; m2_data = '0; m2_cnt = '0;
        m4_we = '0; m4_addr = '0; m4_data = '0; m4_cnt = '0;
    endtask

    task automatic model_edge();
        logic [3:0] e;
        if (flush2) m2_we = '0;
        else if (!stall2) begin
            e = ref_eff(2, {2'b00, we2}, {10'd0, waddr2});
            m2_we = e[1:0]; m2_addr = waddr2; m2_data = wdata2;
            m2_cnt = m2_cnt + 32'($countones(e));
        end
        if (flush4) m4_we = '0;
        else if (!stall4) begin
            e = ref_eff(4, we4, waddr4);
            m4_we = e; m4_addr = waddr4; m4_data = wdata4;
            m4_cnt = 4'((int'(m4_cnt) + $countones(e)) % 16);
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".we2"},   we_o2,    m2_we);
        chk({tag, ".addr2"}, waddr_o2, m2_addr);
        chk({tag, ".data2"}, wdata_o2, m2_data);
        chk({tag, ".cnt2"},  cnt_o2,   m2_cnt);
        chk({tag, ".we4"},   we_o4,    m4_we);
        chk({tag, ".addr4"}, waddr_o4, m4_addr);
        chk({tag, ".data4"}, wdata_o4, m4_data);
        chk({tag, ".cnt4"},  cnt_o4,   m4_cnt);
    endtask

    // Update model from inputs present before the edge, then sample 1 time unit after it.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set2(input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        we2 = we; waddr2 = {a1, a0}; wdata2 = {d1, d0};
    endtask

    logic [31:0] cnt_before;

    initial begin
        rst = 1'b1;
        stall2 = 0; flush2 = 0; we2 = '0; waddr2 = '0; wdata2 = '0;
        stall4 = 0; flush4 = 0; we4 = '0; waddr4 = '0; wdata4 = '0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk); #1;
        check_all("reset_held");
        rst = 1'b0;

        // Load something nonzero so the asynchronous reset has visible effect
        set2(2'b11, 5'd10, 5'd11, 32'h1234_5678, 32'h9ABC_DEF0);
        tick("preload");

        // Async reset mid-cycle with the test bundle already on the inputs
        set2(2'b11, 5'd3, 5'd4, 32'hAAAA_0001, 32'hBBBB_0002);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.we_lit", we_o2, 2'b00);
        rst = 1'b0;
        tick("after_rst");
        chk("after_rst.cnt_lit", cnt_o2, 32'd2);
        chk("after_rst.we_lit", we_o2, 2'b11);

        // Same-address conflict: younger channel wins
        set2(2'b11, 5'd7, 5'd7, 32'h11, 32'h22);
        tick("conflict");
        chk("conflict.we_lit", we_o2, 2'b10);
        chk("conflict.d1_lit", wdata_o2[63:32], 32'h22);
        chk("conflict.cnt_lit", cnt_o2, 32'd3);

        // $0 suppression and idle channel
        set2(2'b01, 5'd0, 5'd9, 32'h33, 32'h44);
        tick("zero_reg");
        chk("zero_reg.we_lit", we_o2, 2'b00);
        chk("zero_reg.cnt_lit", cnt_o2, 32'd3);

        // Stall hold for three cycles with changing inputs
        set2(2'b11, 5'd5, 5'd6, 32'h5555_5555, 32'h6666_6666);
        tick("stall_load");
        cnt_before = cnt_o2;
        stall2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set2(2'b11, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), $urandom, $urandom);
            tick("stall_hold");
            chk("stall_hold.addr_lit", waddr_o2, {5'd6, 5'd5});
        end
        chk("stall.cnt_lit", cnt_o2, cnt_before);
        stall2 = 1'b0;

        // Flush overrides stall
        stall2 = 1'b1; flush2 = 1'b1;
        set2(2'b11, 5'd12, 5'd13, 32'hDEAD_0001, 32'hDEAD_0002);
        tick("flush_stall");
        chk("flush_stall.we_lit", we_o2, 2'b00);
        stall2 = 1'b0; flush2 = 1'b0;
        tick("flush_release");
        chk("flush_release.we_lit", we_o2, 2'b11);

        // 4-issue: 15 single writes, then a 4-wide conflicting bundle wraps the counter
        we2 = '0;
        for (int i = 0; i < 15; i++) begin
            we4 = 4'b0001; waddr4 = {15'd0, 5'(i + 1)}; wdata4 = {96'd0, 32'(i)};
            tick("wrap_fill");
        end
        chk("wrap_fill.cnt_lit", cnt_o4, 4'd15);
        we4 = 4'b1111;
        waddr4 = {5'd2, 5'd9, 5'd9, 5'd9};
        wdata4 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        tick("issue4");
        chk("issue4.we_lit", we_o4, 4'b1100);
        chk("issue4.cnt_lit", cnt_o4, 4'd1);

        // Randomized traffic on both instances with small address space for conflicts
        for (int i = 0; i < 300; i++) begin
            stall2 = ($urandom_range(0, 7) == 0);
            flush2 = ($urandom_range(0, 9) == 0);
            we2    = 2'($urandom);
            waddr2 = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            wdata2 = {$urandom, $urandom};
            stall4 = ($urandom_range(0, 7) == 0);
            flush4 = ($urandom_range(0, 9) == 0);
            we4    = 4'($urandom);
            for (int k = 0; k < 4; k++) waddr4[k*5 +: 5] = 5'($urandom_range(0, 4));
            wdata4 = {$urandom, $urandom, $urandom, $urandom};
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_wb_multi.md
Name: cpu_wb_multi

Overview:
- Parametrised writeback pipeline register for the multi-issue core.
- Captures ISSUE_NUM register-file write requests per cycle from MEM and presents them, registered, to the register file.
- Adds behaviour the single-port stage lacks: stall hold, flush, $0 write suppression, intra-bundle same-address conflict masking, and a retired-write counter for performance monitoring.

Parameters:
- ISSUE_NUM, 2, number of write channels (1..4); channel index order equals program order.
- WORD_W, 32, data width per channel.
- REG_ADDR_W, 5, register address width.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall_i  input  1  hold the current output contents.
- flush_i  input  1  discard the incoming bundle.
- we_i  input  ISSUE_NUM  per-channel write enable.
- waddr_i  input  ISSUE_NUM*REG_ADDR_W  per-channel destination; channel k occupies bits [k*REG_ADDR_W +: REG_ADDR_W].
- wdata_i  input  ISSUE_NUM*WORD_W  per-channel data, packed the same way.
- we_o  output  ISSUE_NUM  registered, masked write enables.
- waddr_o  output  ISSUE_NUM*REG_ADDR_W  registered addresses.
- wdata_o  output  ISSUE_NUM*WORD_W  registered data.
- retired_cnt_o  output  CNT_W  running count of register writes committed.

Behaviour:
- Reset (async, rst=1):
  - we_o, waddr_o, wdata_o and retired_cnt_o all go to 0 immediately, independent of clk.
  - Deassertion takes effect at the next clock edge.
- Latency: 1 cycle, input bundle to outputs, no bypass path.
- Masking, combinational, applied before the register:
  - eff_we[k] = we_i[k] AND (waddr_i[k] != 0) AND NOT(any j>k with we_i[j]=1 and waddr_i[j]=waddr_i[k]).
  - The later channel always wins, so the register file never sees two writes to one address in a cycle.
- Per-edge priority, highest first:
  1. flush_i=1: we_o <= 0; waddr_o and wdata_o are don't-care and are held; counter unchanged. Flush overrides stall.
  2. stall_i=1: all outputs hold; counter unchanged. The register file still sees the held we_o.
  3. Otherwise: we_o <= eff_we; waddr_o and wdata_o <= inputs, unmasked, for all channels; retired_cnt_o <= retired_cnt_o + popcount(eff_we).
- Counter arithmetic:
  - Addition is modulo 2^CNT_W; wrap from all-ones to low bits is silent.
  - popcount is zero-extended to CNT_W.
- Boundary cases:
  - All we_i=0: we_o becomes 0 and the counter does not change.
  - Channel data is never merged or reordered; masking only clears enables.
  - A stall lasting N cycles yields exactly one counted commit for the held bundle, taken on its load cycle.

Decomposition:
- Shared package (cpu_defs.svh):
  - ISSUE_NUM_DEFAULT.
  - Word_t and RegAddr_t, already present.
  - New typedef WbReq_t: struct of we, waddr, wdata.
  - Function popcount_issue.
- Sub-module cpu_wb_conflict_mask:
  - Purely combinational.
  - Inputs we_i and waddr_i; output eff_we.
  - Reused by the ID-stage dual-issue checker.
- Top-level holds:
  - The registers.
  - Stall/flush priority logic.
  - The counter.

Test Plan:
- Async reset: drive we_i=2'b11, addrs 3/4, data 0xAAAA_0001/0xBBBB_0002; pulse rst mid-cycle -> we_o=0, waddr_o=0, wdata_o=0, retired_cnt_o=0 before the next edge; after release, the next edge loads the bundle and retired_cnt_o=2.
- Conflict plus $0 suppression:
  - ch0 we=1 addr=7 data=0x11, ch1 we=1 addr=7 data=0x22 -> we_o=2'b10, wdata_o ch1=0x22, count +1.
  - Then ch0 addr=0, ch1 we=0 -> we_o=2'b00, count +0.
- Stall hold: load addrs 5/6; assert stall_i 3 cycles with changing inputs -> outputs unchanged all 3 cycles, count +2 total, not +8.
- Flush over stall: stall_i=1 and flush_i=1 together with we_i=2'b11 -> we_o=0 next edge, count unchanged; release both -> normal load resumes.
- Counter wrap: CNT_W=4; preload to 15 via 15 single-write cycles, then a 2-write bundle -> retired_cnt_o=1.
- ISSUE_NUM=4 regression: enables 4'b1111, addrs {9,9,9,2} for ch0..ch3 (ch0 and ch1 masked by ch2; ch2 and ch3 kept) -> we_o=4'b1100, count +2.
